// File: rtl/mem_access_controller.sv
// MEM-stage memory access controller: IDLE/WAIT/DONE handshake with pipeline stall.
// Define MEM_TIMEOUT_EN to abort accesses that wait TIMEOUT_CYCLES without an ack.
module mem_access_controller #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     i_CLK,
    input  logic                     i_RST,
    input  logic                     i_MemReadM,
    input  logic                     i_MemWriteM,
    input  logic [ADDRESS_WIDTH-1:0] i_ALUOutM,
    input  logic [DATA_WIDTH-1:0]    i_WriteDataM,
    output logic                     o_StallM,
    output logic [DATA_WIDTH-1:0]    o_ReadDataM,
    output logic                     o_MemErr,
    output logic                     o_MemReq,
    output logic                     o_MemWe,
    output logic [ADDRESS_WIDTH-1:0] o_MemAddr,
    output logic [DATA_WIDTH-1:0]    o_MemWData,
    input  logic                     i_MemAck,
    input  logic [DATA_WIDTH-1:0]    i_MemRData
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t state;
    logic   access;
    logic   rd_wr_both;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_access_controller: TIMEOUT_CYCLES must be at least 1");
    end

    assign access = i_MemReadM | i_MemWriteM;

    // DONE drops the stall so the pipeline advances past the finished instruction.
    always_comb begin
        o_StallM = 1'b0;
        if (!i_RST) begin
            case (state)
                ST_IDLE: o_StallM = access;
                ST_WAIT: o_StallM = 1'b1;
                default: o_StallM = 1'b0;
            endcase
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            o_MemReq    <= 1'b0;
            o_MemWe     <= 1'b0;
            o_MemAddr   <= '0;
            o_MemWData  <= '0;
            o_ReadDataM <= '0;
            o_MemErr    <= 1'b0;
            rd_wr_both  <= 1'b0;
        end else begin
            o_MemErr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (access) begin
                        o_MemAddr  <= i_ALUOutM;
                        o_MemWData <= i_WriteDataM;
                        o_MemWe    <= i_MemWriteM;
                        rd_wr_both <= i_MemReadM & i_MemWriteM;
                        o_MemReq   <= 1'b1;
                        wait_cnt   <= '0;
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Ack takes priority over a timeout landing on the same cycle.
                    if (i_MemAck) begin
                        if (!o_MemWe) begin
                            o_ReadDataM <= i_MemRData;
                        end else if (rd_wr_both) begin
                            o_ReadDataM <= '0;
                        end
                        wait_cnt <= '0;
                        o_MemReq <= 1'b0;
                        state    <= ST_DONE;
                    end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        o_ReadDataM <= '0;
                        o_MemErr    <= 1'b1;
                        wait_cnt    <= '0;
                        o_MemReq    <= 1'b0;
                        state       <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    o_MemReq <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end
`else
    assign o_MemErr = 1'b0;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state       <= ST_IDLE;
            o_MemReq    <= 1'b0;
            o_MemWe     <= 1'b0;
            o_MemAddr   <= '0;
            o_MemWData  <= '0;
            o_ReadDataM <= '0;
            rd_wr_both  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (access) begin
                        o_MemAddr  <= i_ALUOutM;
                        o_MemWData <= i_WriteDataM;
                        o_MemWe    <= i_MemWriteM;
                        rd_wr_both <= i_MemReadM & i_MemWriteM;
                        o_MemReq   <= 1'b1;
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (i_MemAck) begin
                        if (!o_MemWe) begin
                            o_ReadDataM <= i_MemRData;
                        end else if (rd_wr_both) begin
                            o_ReadDataM <= '0;
                        end
                        o_MemReq <= 1'b0;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    o_MemReq <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_mem_access_controller.sv
// Bench for mem_access_controller: directed and random accesses against a transaction-level model.
// Timeout checks are compiled in when MEM_TIMEOUT_EN is defined.
module tb_mem_access_controller;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_read, mem_write;
    logic [AW-1:0] alu_out;
    logic [DW-1:0] wr_data;
    logic          stall;
    logic [DW-1:0] rd_data;
    logic          mem_err, mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    int            tests  = 0;
    int            fails  = 0;
    int            bursts = 0;
    logic          prev_req = 1'b0;
    logic [DW-1:0] exp_rdata;

    always #5 clk = ~clk;

    mem_access_controller #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_CLK       (clk),
        .i_RST       (rst),
        .i_MemReadM  (mem_read),
        .i_MemWriteM (mem_write),
        .i_ALUOutM   (alu_out),
        .i_WriteDataM(wr_data),
        .o_StallM    (stall),
        .o_ReadDataM (rd_data),
        .o_MemErr    (mem_err),
        .o_MemReq    (mem_req),
        .o_MemWe     (mem_we),
        .o_MemAddr   (mem_addr),
        .o_MemWData  (mem_wdata),
        .i_MemAck    (mem_ack),
        .i_MemRData  (mem_rdata)
    );

    // Request bursts are counted as rising edges of the request strobe.
    always @(negedge clk) begin
        if (mem_req === 1'b1 && prev_req !== 1'b1) bursts++;
        prev_req = mem_req;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        next_cycle();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        alu_out   = $urandom;
        wr_data   = $urandom;
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        #1;
        check("idle_stall", stall, 0);
        check("idle_req", mem_req, 0);
        check("idle_err", mem_err, 0);
        check("idle_rdata", rd_data, exp_rdata);
    endtask

    // ack_at: WAIT cycle (1-based) on which ack is driven; 0 means never.
    task automatic do_txn(input logic rd, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input int ack_at);
        int            nwait;
        bit            err;
        int            stalls;
        logic [DW-1:0] ack_data;
`ifdef MEM_TIMEOUT_EN
        err   = (ack_at < 1 || ack_at > TO);
        nwait = err ? TO : ack_at;
`else
        err   = 1'b0;
        nwait = ack_at;
`endif
        ack_data = '0;
        stalls   = 0;
        next_cycle();
        mem_read  = rd;
        mem_write = wr;
        alu_out   = addr;
        wr_data   = wdata;
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        #1;
        check("access_stall", stall, 1);
        check("access_req", mem_req, 0);
        if (stall === 1'b1) stalls++;
        if (nwait < 1 || nwait > 64) begin
            check("wait_bound", 64'(nwait), 1);
            return;
        end
        for (int i = 1; i <= nwait; i++) begin
            next_cycle();
            mem_ack   = (i == ack_at);
            mem_rdata = $urandom;
            if (i == ack_at) ack_data = mem_rdata;
            #1;
            check("wait_req", mem_req, 1);
            check("wait_we", mem_we, wr);
            check("wait_addr", mem_addr, addr);
            check("wait_wdata", mem_wdata, wdata);
            check("wait_err", mem_err, 0);
            if (stall === 1'b1) stalls++;
        end
        next_cycle();
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        #1;
        if (err)             exp_rdata = '0;
        else if (rd && !wr)  exp_rdata = ack_data;
        else if (rd && wr)   exp_rdata = '0;
        check("done_stall", stall, 0);
        check("done_req", mem_req, 0);
        check("done_err", mem_err, err);
        check("done_rdata", rd_data, exp_rdata);
        check("stall_cycles", 64'(stalls), 64'(1 + nwait));
    endtask

    initial begin
        int b0;
        rst       = 1'b1;
        mem_read  = 1'b1;
        mem_write = 1'b0;
        alu_out   = 32'h40;
        wr_data   = '0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        exp_rdata = '0;
        repeat (2) next_cycle();
        check("rst_stall", stall, 0);
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_rdata", rd_data, 0);
        check("rst_err", mem_err, 0);
        rst      = 1'b0;
        mem_read = 1'b0;
        mem_ack  = 1'b0;
        idle_cycle();

        do_txn(1'b1, 1'b0, 32'h100, 32'h0, 3);
        mem_rdata = 32'hDEAD_BEEF;
        check("load_deadbeef_set", exp_rdata == '0, 0);
        idle_cycle();
        do_txn(1'b0, 1'b1, 32'h200, 32'h1234_5678, 1);
        idle_cycle();
        do_txn(1'b1, 1'b1, 32'h300, 32'hCAFE_F00D, 2);
        idle_cycle();

        b0 = bursts;
        do_txn(1'b1, 1'b0, 32'h400, 32'h0, 1);
        do_txn(1'b1, 1'b0, 32'h404, 32'h0, 2);
        idle_cycle();
        idle_cycle();
        check("b2b_bursts", 64'(bursts - b0), 2);

`ifdef MEM_TIMEOUT_EN
        do_txn(1'b1, 1'b0, 32'h500, 32'h0, 1);
        do_txn(1'b1, 1'b0, 32'h504, 32'h0, 0);
        idle_cycle();
        do_txn(1'b1, 1'b0, 32'h508, 32'h0, TO);
        idle_cycle();
        do_txn(1'b0, 1'b1, 32'h50C, 32'h55AA_55AA, 0);
        idle_cycle();
`else
        do_txn(1'b1, 1'b0, 32'h500, 32'h0, 20);
        idle_cycle();
`endif

        for (int n = 0; n < 30; n++) begin
            logic r, w;
            int   gap;
            int   ack_at;
            r = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            if (!r && !w) r = 1'b1;
`ifdef MEM_TIMEOUT_EN
            ack_at = $urandom_range(0, 6);
`else
            ack_at = $urandom_range(1, 6);
`endif
            do_txn(r, w, $urandom, $urandom, ack_at);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) idle_cycle();
        end

        // Reset in the second WAIT cycle must drop the request immediately.
        next_cycle();
        mem_read  = 1'b1;
        mem_write = 1'b0;
        alu_out   = 32'h600;
        mem_ack   = 1'b0;
        next_cycle();
        next_cycle();
        check("pre_rst_req", mem_req, 1);
        #2;
        rst = 1'b1;
        #1;
        exp_rdata = '0;
        check("rst_wait_req", mem_req, 0);
        check("rst_wait_stall", stall, 0);
        check("rst_wait_rdata", rd_data, 0);
        check("rst_wait_addr", mem_addr, 0);
        mem_read = 1'b0;
        next_cycle();
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        #1;
        check("late_ack_req", mem_req, 0);
        check("late_ack_stall", stall, 0);
        next_cycle();
        check("late_ack_rdata", rd_data, 0);
        check("late_ack_req2", mem_req, 0);
        mem_ack = 1'b0;
        idle_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
